// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin handshake arbiters.
package arb_pkg;

    localparam int unsigned MAX_REQ = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Advance a round-robin index, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or above start, wrapping.
module rr_priority_pick #(
    parameter int unsigned num_req  = 4,
    parameter int unsigned id_width = $clog2(num_req)
) (
    input  logic [num_req-1:0]  req,
    input  logic [id_width-1:0] start,
    output logic                found_c,
    output logic [id_width-1:0] winner_c
);

    int unsigned idx;

    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        idx      = 0;
        for (int unsigned off = 0; off < num_req; off++) begin
            idx = 32'(start) + off;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (!found_c && req[idx]) begin
                found_c  = 1'b1;
                winner_c = id_width'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// N-to-1 round-robin arbiter onto one REQ/ACK channel with a registered output
// stage and optional per-beat grant locking for multi-beat packets.
module rr_handshake_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned  bit_width = 32,
    parameter int unsigned  num_req   = 4,
    localparam int unsigned id_width  = $clog2(num_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [num_req-1:0]            dInREQ,
    input  logic [num_req-1:0]            dInACK,
    input  logic [num_req-1:0]            dInLOCK,
    input  logic [num_req*bit_width-1:0]  dIN,
    output logic                          dOutACK,
    input  logic                          dOutREQ,
    output logic [bit_width-1:0]          dOUT,
    output logic [id_width-1:0]           dOutID,
    output logic                          locked
);

    if (num_req < 2 || num_req > MAX_REQ) begin : g_bad_num_req
        $error("rr_handshake_arbiter: num_req out of range");
    end

    arb_state_t            state_q, state_d;
    logic [id_width-1:0]   ptr_q, ptr_d;
    logic [id_width-1:0]   owner_q, owner_d;
    logic [bit_width-1:0]  dout_q, dout_d;
    logic [id_width-1:0]   dout_id_q, dout_id_d;
    logic                  dout_ack_q, dout_ack_d;

    logic                  accept_c;
    logic                  fire_c;
    logic [num_req-1:0]    cand_c;
    logic [id_width-1:0]   start_c;
    logic                  found_c;
    logic [id_width-1:0]   winner_c;
    logic [bit_width-1:0]  beat_c;
    logic                  lock_c;

    // While locked only the owner may compete, so the picker sees a one-hot mask.
    always_comb begin
        cand_c  = dInACK;
        start_c = ptr_q;
        if (state_q == LOCKED) begin
            cand_c          = '0;
            cand_c[owner_q] = dInACK[owner_q];
            start_c         = owner_q;
        end
    end

    rr_priority_pick #(
        .num_req  (num_req),
        .id_width (id_width)
    ) u_pick (
        .req      (cand_c),
        .start    (start_c),
        .found_c  (found_c),
        .winner_c (winner_c)
    );

    always_comb begin
        beat_c = '0;
        lock_c = 1'b0;
        for (int unsigned i = 0; i < num_req; i++) begin
            if (winner_c == id_width'(i)) begin
                beat_c = dIN[i*bit_width +: bit_width];
                lock_c = dInLOCK[i];
            end
        end
    end

    // Grant and next-state; the stage refills in the same cycle it drains.
    always_comb begin
        accept_c   = !dout_ack_q || dOutREQ;
        fire_c     = 1'b0;
        dInREQ     = '0;
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        dout_d     = dout_q;
        dout_id_d  = dout_id_q;
        dout_ack_d = dout_ack_q;

        if (!rst && accept_c && found_c) begin
            fire_c           = 1'b1;
            dInREQ[winner_c] = 1'b1;
        end

        if (fire_c) begin
            dout_d     = beat_c;
            dout_id_d  = winner_c;
            dout_ack_d = 1'b1;
            ptr_d      = id_width'(wrap_inc(32'(winner_c), num_req));
            if (lock_c) begin
                state_d = LOCKED;
                owner_d = winner_c;
            end else begin
                state_d = ARB;
            end
        end else if (dout_ack_q && dOutREQ) begin
            dout_ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            dout_q     <= '0;
            dout_id_q  <= '0;
            dout_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            dout_q     <= dout_d;
            dout_id_q  <= dout_id_d;
            dout_ack_q <= dout_ack_d;
        end
    end

    assign dOutACK = dout_ack_q;
    assign dOUT    = dout_q;
    assign dOutID  = dout_id_q;
    assign locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed bench for rr_handshake_arbiter (num_req=4, bit_width=32).
module tb_rr_handshake_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     dInREQ;
    logic [NR-1:0]     dInACK;
    logic [NR-1:0]     dInLOCK;
    logic [NR*BW-1:0]  dIN;
    logic              dOutACK;
    logic              dOutREQ;
    logic [BW-1:0]     dOUT;
    logic [IW-1:0]     dOutID;
    logic              locked;

    int checks = 0;
    int errors = 0;

    rr_handshake_arbiter #(
        .bit_width (BW),
        .num_req   (NR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dInREQ  (dInREQ),
        .dInACK  (dInACK),
        .dInLOCK (dInLOCK),
        .dIN     (dIN),
        .dOutACK (dOutACK),
        .dOutREQ (dOutREQ),
        .dOUT    (dOUT),
        .dOutID  (dOutID),
        .locked  (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ack, input logic [31:0] data,
                             input logic [1:0] id, input logic lk);
        check({tag, ".ack"},    32'(dOutACK), 32'(ack));
        check({tag, ".dout"},   dOUT,         data);
        check({tag, ".id"},     32'(dOutID),  32'(id));
        check({tag, ".locked"}, 32'(locked),  32'(lk));
    endtask

    task automatic check_req(input string tag, input logic [3:0] exp);
        #1;
        check({tag, ".req"}, 32'(dInREQ), 32'(exp));
    endtask

    initial begin
        rst     = 1'b1;
        dInACK  = '0;
        dInLOCK = '0;
        dOutREQ = 1'b0;
        dIN     = '0;
        for (int i = 0; i < 4; i++) dIN[i*BW +: BW] = 32'h100 + 32'(i);

        // Reset then idle
        step();
        check_req("rst_hold", 4'b0000);
        step();
        rst = 1'b0;
        step();
        check_out("idle", 1'b0, 32'h0, 2'd0, 1'b0);
        check_req("idle", 4'b0000);

        // Full contention, consumer always ready
        dInACK  = 4'b1111;
        dOutREQ = 1'b1;
        check_req("rr_g0", 4'b0001);
        step(); check_out("rr_b0", 1'b1, 32'h100, 2'd0, 1'b0); check_req("rr_g1", 4'b0010);
        step(); check_out("rr_b1", 1'b1, 32'h101, 2'd1, 1'b0); check_req("rr_g2", 4'b0100);
        step(); check_out("rr_b2", 1'b1, 32'h102, 2'd2, 1'b0); check_req("rr_g3", 4'b1000);
        step(); check_out("rr_b3", 1'b1, 32'h103, 2'd3, 1'b0); check_req("rr_g4", 4'b0001);
        step(); check_out("rr_b4", 1'b1, 32'h100, 2'd0, 1'b0);

        // Backpressure: stage full, only requester 2 valid
        dOutREQ = 1'b0;
        dInACK  = 4'b0100;
        check_req("bp_0", 4'b0000);
        for (int c = 0; c < 3; c++) begin
            step();
            check_out("bp_hold", 1'b1, 32'h100, 2'd0, 1'b0);
            check_req("bp_hold", 4'b0000);
        end
        dOutREQ = 1'b1;
        check_req("bp_release", 4'b0100);
        step(); check_out("bp_beat", 1'b1, 32'h102, 2'd2, 1'b0);
        dInACK = 4'b0000;
        check_req("drain", 4'b0000);
        step(); check_out("drain", 1'b0, 32'h102, 2'd2, 1'b0);

        // Wrap: pointer at 3, only requester 0 valid
        dInACK = 4'b0001;
        check_req("wrap", 4'b0001);
        step(); check_out("wrap", 1'b1, 32'h100, 2'd0, 1'b0);

        // Lock: requester 1 sends 3 beats while requester 3 waits (pointer now 1)
        dInACK  = 4'b1010;
        dInLOCK = 4'b0010;
        dIN[1*BW +: BW] = 32'hA1;
        check_req("lk_g0", 4'b0010);
        step(); check_out("lk_b0", 1'b1, 32'hA1, 2'd1, 1'b1);
        dIN[1*BW +: BW] = 32'hA2;
        check_req("lk_g1", 4'b0010);
        step(); check_out("lk_b1", 1'b1, 32'hA2, 2'd1, 1'b1);
        dIN[1*BW +: BW] = 32'hA3;
        dInLOCK = 4'b0000;
        check_req("lk_g2", 4'b0010);
        step(); check_out("lk_b2", 1'b1, 32'hA3, 2'd1, 1'b0);
        dInACK = 4'b1000;
        check_req("lk_next", 4'b1000);
        step(); check_out("lk_next", 1'b1, 32'h103, 2'd3, 1'b0);

        // Reset mid-packet: requester 2 locks, then rst with the stage full
        dInACK  = 4'b0100;
        dInLOCK = 4'b0100;
        dIN[2*BW +: BW] = 32'hB2;
        check_req("rm_g", 4'b0100);
        step(); check_out("rm_beat", 1'b1, 32'hB2, 2'd2, 1'b1);
        dOutREQ = 1'b0;
        dInACK  = 4'b1111;
        dInLOCK = 4'b0000;
        #1;
        rst = 1'b1;
        #1;
        check_out("rm_rst", 1'b0, 32'h0, 2'd0, 1'b0);
        check_req("rm_rst", 4'b0000);
        step();
        rst     = 1'b0;
        dOutREQ = 1'b1;
        check_req("rm_restart", 4'b0001);
        step(); check_out("rm_restart", 1'b1, 32'h100, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
